// File: rtl/tank_sprite_fetch.sv
// Per-pixel tank sprite fetch: per-frame position/heading latch, rotated ROM address, registered palette index.
// Define TANK_HIT_FLASH_EN to build the hit-flash counter that substitutes FLASH_IDX on opaque pixels.
module tank_sprite_fetch #(
  parameter int SPR_S        = 32,
  parameter int ADDR_W       = 10,
  parameter int TRANSP_IDX   = 0,
  parameter int FLASH_FRAMES = 16,
  parameter int FLASH_IDX    = 11
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_ce,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        tank_x,
  input  logic [9:0]        tank_y,
  input  logic [1:0]        tank_dir,
  input  logic              hit,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pix_index,
  output logic              pix_opaque
);

  localparam int OFF_W = $clog2(SPR_S);

  logic [9:0]       sx, sy;
  logic [1:0]       sdir;
  logic             shadow_valid;
  logic             in_box1;
  logic             in_box;
  logic [OFF_W-1:0] lx, ly, rx, ry;
  logic [3:0]       out_index;

  // Shadow copy of the tank pose, refreshed only at vertical blank so the sprite never tears.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sx           <= '0;
      sy           <= '0;
      sdir         <= '0;
      shadow_valid <= 1'b0;
    end else if (frame_start) begin
      sx           <= tank_x;
      sy           <= tank_y;
      sdir         <= tank_dir;
      shadow_valid <= 1'b1;
    end
  end

  // Box test uses 11-bit sums so a sprite hanging off the right/bottom edge clips instead of wrapping.
  always_comb begin
    in_box = shadow_valid &&
             ({1'b0, DrawX} >= {1'b0, sx}) && ({1'b0, DrawX} < ({1'b0, sx} + 11'(SPR_S))) &&
             ({1'b0, DrawY} >= {1'b0, sy}) && ({1'b0, DrawY} < ({1'b0, sy} + 11'(SPR_S)));
    lx = OFF_W'(DrawX - sx);
    ly = OFF_W'(DrawY - sy);
    rx = lx;
    ry = ly;
    case (sdir)
      2'd1: begin
        rx = ly;
        ry = OFF_W'(SPR_S - 1) - lx;
      end
      2'd2: begin
        rx = OFF_W'(SPR_S - 1) - lx;
        ry = OFF_W'(SPR_S - 1) - ly;
      end
      2'd3: begin
        rx = OFF_W'(SPR_S - 1) - ly;
        ry = lx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      in_box1  <= 1'b0;
    end else if (pix_ce) begin
      in_box1 <= in_box;
      if (in_box)
        rom_addr <= ADDR_W'(ry) * ADDR_W'(SPR_S) + ADDR_W'(rx);
    end
  end

`ifdef TANK_HIT_FLASH_EN
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

  logic [FLASH_W-1:0] flash_cnt;

  // A hit reloads the counter even on the frame_start that would otherwise decrement it.
  always_ff @(posedge Clk) begin
    if (Reset)
      flash_cnt <= '0;
    else if (hit)
      flash_cnt <= FLASH_W'(FLASH_FRAMES);
    else if (frame_start && (flash_cnt != '0))
      flash_cnt <= flash_cnt - 1'b1;
  end

  always_comb begin
    out_index = rom_data;
    if ((flash_cnt != '0) && flash_cnt[0])
      out_index = 4'(FLASH_IDX);
  end
`else
  logic unused_hit;
  assign unused_hit = hit;

  always_comb begin
    out_index = rom_data;
  end
`endif

  // Transparency always follows the ROM value, even while the flash colour is substituted.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_index  <= '0;
      pix_opaque <= 1'b0;
    end else if (pix_ce) begin
      pix_index  <= out_index;
      pix_opaque <= in_box1 && (rom_data != 4'(TRANSP_IDX));
    end
  end

endmodule

// File: tb/tb_tank_sprite_fetch.sv
// Directed bench for tank_sprite_fetch: latch, rotation, clipping, stall, reset and (optionally) hit flash.
module tb_tank_sprite_fetch;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       pix_ce;
  logic       frame_start;
  logic [9:0] DrawX, DrawY;
  logic [9:0] tank_x, tank_y;
  logic [1:0] tank_dir;
  logic       hit;
  logic [9:0] rom_addr;
  logic [3:0] rom_data;
  logic [3:0] pix_index;
  logic       pix_opaque;

  int checks = 0;
  int passes = 0;

  tank_sprite_fetch dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .pix_ce     (pix_ce),
    .frame_start(frame_start),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .tank_x     (tank_x),
    .tank_y     (tank_y),
    .tank_dir   (tank_dir),
    .hit        (hit),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_index  (pix_index),
    .pix_opaque (pix_opaque)
  );

  always #5 Clk = ~Clk;

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic [3:0] d);
    DrawX    = x;
    DrawY    = y;
    rom_data = d;
    @(negedge Clk) pix_ce = 1'b1;
    @(negedge Clk) pix_ce = 1'b0;
  endtask

  task automatic pulseFrame();
    @(negedge Clk) frame_start = 1'b1;
    @(negedge Clk) frame_start = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  initial begin
    Reset = 1'b1; pix_ce = 1'b0; frame_start = 1'b0; hit = 1'b0;
    DrawX = '0; DrawY = '0; tank_x = '0; tank_y = '0; tank_dir = '0; rom_data = '0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    checkOutput("reset_addr", rom_addr, 0);
    checkOutput("reset_index", pix_index, 0);
    checkOutput("reset_opaque", pix_opaque, 0);

    applyStimulus(105, 203, 5);
    applyStimulus(105, 203, 5);
    checkOutput("noframe_opaque", pix_opaque, 0);
    checkOutput("noframe_index", pix_index, 5);
    checkOutput("noframe_addr", rom_addr, 0);

    tank_x = 100; tank_y = 200; tank_dir = 0;
    pulseFrame();
    applyStimulus(105, 203, 7);
    checkOutput("dir0_addr", rom_addr, 101);
    applyStimulus(105, 203, 7);
    checkOutput("dir0_index", pix_index, 7);
    checkOutput("dir0_opaque", pix_opaque, 1);

    tank_dir = 1; pulseFrame();
    applyStimulus(105, 203, 7);
    checkOutput("dir1_addr", rom_addr, 835);
    tank_dir = 2; pulseFrame();
    applyStimulus(105, 203, 7);
    checkOutput("dir2_addr", rom_addr, 922);
    tank_dir = 3; pulseFrame();
    applyStimulus(105, 203, 7);
    checkOutput("dir3_addr", rom_addr, 188);

    tank_dir = 0; pulseFrame();
    applyStimulus(99, 200, 7);
    applyStimulus(99, 200, 7);
    checkOutput("left_edge_opaque", pix_opaque, 0);
    applyStimulus(131, 231, 7);
    checkOutput("corner_addr", rom_addr, 1023);
    applyStimulus(131, 231, 7);
    checkOutput("corner_opaque", pix_opaque, 1);
    applyStimulus(132, 200, 7);
    checkOutput("right_edge_hold_addr", rom_addr, 1023);
    applyStimulus(132, 200, 7);
    checkOutput("right_edge_opaque", pix_opaque, 0);
    applyStimulus(110, 210, 0);
    applyStimulus(110, 210, 0);
    checkOutput("transp_opaque", pix_opaque, 0);
    checkOutput("transp_index", pix_index, 0);

    tank_x = 620; tank_y = 470; pulseFrame();
    applyStimulus(639, 479, 7);
    checkOutput("clip_addr", rom_addr, 307);
    applyStimulus(639, 479, 7);
    checkOutput("clip_opaque", pix_opaque, 1);
    applyStimulus(5, 5, 7);
    applyStimulus(5, 5, 7);
    checkOutput("nowrap_opaque", pix_opaque, 0);

    tank_x = 300;
    applyStimulus(639, 479, 7);
    checkOutput("midframe_addr", rom_addr, 307);
    applyStimulus(639, 479, 7);
    checkOutput("midframe_opaque", pix_opaque, 1);

    DrawX = 620; DrawY = 10; rom_data = 3;
    repeat (10) @(negedge Clk);
    checkOutput("stall_addr", rom_addr, 307);
    checkOutput("stall_index", pix_index, 7);
    checkOutput("stall_opaque", pix_opaque, 1);

    DrawX = 305; DrawY = 479; rom_data = 7;
    @(negedge Clk) begin frame_start = 1'b1; pix_ce = 1'b1; end
    @(negedge Clk) begin frame_start = 1'b0; pix_ce = 1'b0; end
    checkOutput("coincident_old_shadow", rom_addr, 307);
    applyStimulus(305, 479, 7);
    checkOutput("coincident_new_shadow", rom_addr, 293);

    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    checkOutput("midreset_addr", rom_addr, 0);
    checkOutput("midreset_opaque", pix_opaque, 0);
    applyStimulus(305, 479, 7);
    applyStimulus(305, 479, 7);
    checkOutput("midreset_nodraw", pix_opaque, 0);
    checkOutput("midreset_addr_hold", rom_addr, 0);

    pulseFrame();
    @(negedge Clk) hit = 1'b1;
    @(negedge Clk) hit = 1'b0;
    repeat (3) pulseFrame();
    applyStimulus(305, 479, 7);
    applyStimulus(305, 479, 7);
`ifdef TANK_HIT_FLASH_EN
    checkOutput("flash_index", pix_index, 11);
    checkOutput("flash_opaque", pix_opaque, 1);
    applyStimulus(305, 479, 0);
    applyStimulus(305, 479, 0);
    checkOutput("flash_transp_opaque", pix_opaque, 0);
    repeat (13) pulseFrame();
    applyStimulus(305, 479, 7);
    applyStimulus(305, 479, 7);
    checkOutput("flash_done_index", pix_index, 7);
    checkOutput("flash_done_opaque", pix_opaque, 1);
`else
    checkOutput("hit_ignored_index", pix_index, 7);
    checkOutput("hit_ignored_opaque", pix_opaque, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/tank_sprite_fetch.md
Name: tank_sprite_fetch

Overview:
- Per-pixel sprite fetch stage sitting directly upstream of the tank palette lookup.
- Takes the VGA scan position and the tank's position and heading.
- Computes the rotated sprite-ROM address, drives a 1-clock synchronous sprite ROM, and emits a registered 4-bit palette index plus an opaque flag.
- Position and heading are latched once per frame so the tank never tears mid-frame.

Parameters:
- SPR_S, 32: sprite side in pixels; sprite is square.
- ADDR_W, 10: ROM address width; must equal clog2(SPR_S*SPR_S).
- TRANSP_IDX, 0: palette index treated as transparent.
- FLASH_FRAMES, 16: flash duration in frames (optional feature only).
- FLASH_IDX, 11: palette index substituted during flash (optional feature only).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- pix_ce  in  1  pixel-beat enable; never high on two consecutive clocks.
- frame_start  in  1  one-clock pulse at start of vertical blank.
- DrawX  in  10  current scan column.
- DrawY  in  10  current scan row.
- tank_x  in  10  sprite top-left column (unsigned).
- tank_y  in  10  sprite top-left row (unsigned).
- tank_dir  in  2  heading: 0 up, 1 right, 2 down, 3 left.
- hit  in  1  one-clock pulse when the tank is struck.
- rom_addr  out  ADDR_W  sprite ROM read address.
- rom_data  in  4  ROM palette index, valid 1 clock after rom_addr.
- pix_index  out  4  palette index for the downstream palette lookup.
- pix_opaque  out  1  1 = draw pix_index; 0 = show background.

Behaviour:
- Clock and reset: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset values:
  - rom_addr, pix_index, pix_opaque = 0.
  - Shadow position and heading = 0.
  - shadow_valid = 0.
  - Flash counter = 0.
- Shadow latch:
  - On frame_start, capture tank_x, tank_y and tank_dir into shadow registers and set shadow_valid = 1.
  - Changes to tank_x, tank_y and tank_dir between pulses have no visible effect.
- Stage 1 (each pix_ce):
  - Compute lx = DrawX - sx_shadow and ly = DrawY - sy_shadow.
  - in_box = shadow_valid && DrawX >= sx_shadow && DrawX < sx_shadow + SPR_S && the same test on Y.
  - Sums are 11-bit, so a sprite partly off the right or bottom edge clips and does not wrap.
  - Register rom_addr = ry*SPR_S + rx and in_box1. Out of box, rom_addr holds its previous value.
- Rotation (S = SPR_S), giving (rx, ry):
  - dir 0: (lx, ly).
  - dir 1: (ly, S-1-lx).
  - dir 2: (S-1-lx, S-1-ly).
  - dir 3: (S-1-ly, lx).
- Stage 2 (next pix_ce):
  - pix_index = rom_data.
  - pix_opaque = in_box1 && rom_data != TRANSP_IDX.
- Latency: 2 pix_ce beats from DrawX/DrawY sampled to pix_index/pix_opaque valid.
- Stall: with pix_ce low, all pipeline registers hold. rom_addr stable means rom_data stable.
- frame_start coincident with pix_ce: the latch updates; the pixel in stage 1 on that beat uses the old shadow.
- Reset mid-frame:
  - Pipeline cleared.
  - Nothing drawn until the next frame_start.

Optional Feature:
- Macro: TANK_HIT_FLASH_EN.
- Defined:
  - hit loads the flash counter with FLASH_FRAMES; a new hit reloads it.
  - Each frame_start decrements the counter when nonzero.
  - While the counter is nonzero and odd, opaque pixels output pix_index = FLASH_IDX.
  - Transparency is still decided from rom_data.
  - hit coincident with frame_start: the load wins.
- Undefined:
  - hit is ignored and no counter is synthesized.
  - Output is always rom_data.

Test Plan:
- Reset, no frame_start, scan (105,203) with rom_data=5 -> pix_opaque=0, pix_index=5.
- frame_start with tank=(100,200), dir 0; scan (105,203) -> rom_addr=101; two beats later, rom_data=7 gives pix_index=7, pix_opaque=1.
- Same pixel with dir 1 -> rom_addr=835. With dir 2 -> rom_addr=922. With dir 3 -> rom_addr=5*32+28=188.
- Boundaries with tank at (100,200):
  - (99,200) -> opaque 0.
  - (131,231) -> opaque 1.
  - (132,200) -> opaque 0.
  - rom_data=0 inside the box -> opaque 0.
- Tank at (620,470), scan (639,479) -> in box, rom_addr=9*32+19=307, no wrap.
- Change tank_x mid-frame -> addresses unchanged until frame_start.
- pix_ce held low 10 clocks -> outputs constant.
- Flash, with macro defined: hit, then 3 frame_starts -> counter=13, opaque pixels show index 11. After 16 frames -> normal output.
